// File: rtl/multicycle_pkg.sv
// Shared types for the multicycle controller: FSM states, instruction classes,
// the RV32 major opcodes it understands and the decode helper that classifies them.
package multicycle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6,
    ST_FAULT     = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    OC_NONE    = 3'd0,
    OC_ALU     = 3'd1,
    OC_LOAD    = 3'd2,
    OC_STORE   = 3'd3,
    OC_BRANCH  = 3'd4,
    OC_JUMP    = 3'd5,
    OC_SYSTEM  = 3'd6,
    OC_ILLEGAL = 3'd7
  } op_class_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic op_class_e classify(input logic [6:0] op);
    case (op)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: classify = OC_ALU;
      OPC_LOAD:                               classify = OC_LOAD;
      OPC_STORE:                              classify = OC_STORE;
      OPC_BRANCH:                             classify = OC_BRANCH;
      OPC_JAL, OPC_JALR:                      classify = OC_JUMP;
      OPC_SYSTEM:                             classify = OC_SYSTEM;
      default:                                classify = OC_ILLEGAL;
    endcase
  endfunction

  function automatic logic [2:0] state_bits(input state_e s);
    return s;
  endfunction

endpackage

// File: rtl/multicycle_controller_wait_timer.sv
// Wait-cycle counter for the FETCH/MEMORY handshakes; expired marks the last
// permitted wait cycle so the FSM can fault if ready does not arrive in it.
module wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  logic [TW-1:0] r_count;

  // Count wait cycles; clear has priority so each new wait starts from zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (tick) begin
      r_count <= r_count + TW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign expired = (r_count == TW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle sequencing FSM: steps the shared datapath through fetch, decode,
// execute, memory and writeback, gating every state-changing write and counting retires.
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [6:0]             opcode,
  output logic                   imem_req,
  input  logic                   imem_ready,
  input  logic                   dmem_ready,
  input  logic                   branch_taken,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   next_pc_src,
  output logic                   ru_write_en,
  output logic                   dm_req,
  output logic                   dm_write_en,
  output logic                   retire,
  output logic [COUNT_WIDTH-1:0] instr_count,
  output logic [2:0]             state,
  output logic                   halted,
  output logic                   fault
);

  state_e                 r_state;
  state_e                 w_next_state;
  op_class_e              r_op_class;
  op_class_e              w_decoded;
  logic [COUNT_WIDTH-1:0] r_instr_count;
  logic                   w_in_wait;
  logic                   w_ready;
  logic                   w_expired;

  assign w_decoded = classify(opcode);
  assign w_in_wait = (r_state == ST_FETCH) || (r_state == ST_MEMORY);
  assign w_ready   = ((r_state == ST_FETCH) && imem_ready) ||
                     ((r_state == ST_MEMORY) && dmem_ready);

  wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!w_in_wait || w_ready),
    .tick   (w_in_wait && !w_ready),
    .expired(w_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Instruction class is latched in DECODE and steers the later phases.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_op_class <= OC_NONE;
    end else if (r_state == ST_DECODE) begin
      r_op_class <= w_decoded;
    end else begin
      r_op_class <= r_op_class;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_instr_count <= '0;
    end else if (retire) begin
      r_instr_count <= r_instr_count + COUNT_WIDTH'(1);
    end else begin
      r_instr_count <= r_instr_count;
    end
  end

  // Next-state logic; ready wins over the timeout in the same cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = ST_FETCH;
        else       w_next_state = ST_IDLE;
      end
      ST_FETCH: begin
        if (imem_ready)     w_next_state = ST_DECODE;
        else if (w_expired) w_next_state = ST_FAULT;
        else                w_next_state = ST_FETCH;
      end
      ST_DECODE: begin
        case (w_decoded)
          OC_SYSTEM:  w_next_state = ST_HALT;
          OC_ILLEGAL: w_next_state = ST_FAULT;
          default:    w_next_state = ST_EXECUTE;
        endcase
      end
      ST_EXECUTE: begin
        case (r_op_class)
          OC_BRANCH:          w_next_state = ST_FETCH;
          OC_LOAD, OC_STORE:  w_next_state = ST_MEMORY;
          OC_ALU, OC_JUMP:    w_next_state = ST_WRITEBACK;
          default:            w_next_state = ST_FAULT;
        endcase
      end
      ST_MEMORY: begin
        if (dmem_ready) begin
          if (r_op_class == OC_STORE) w_next_state = ST_FETCH;
          else                        w_next_state = ST_WRITEBACK;
        end else if (w_expired) begin
          w_next_state = ST_FAULT;
        end else begin
          w_next_state = ST_MEMORY;
        end
      end
      ST_WRITEBACK: w_next_state = ST_FETCH;
      ST_HALT:      w_next_state = ST_HALT;
      ST_FAULT:     w_next_state = ST_FAULT;
      default:      w_next_state = ST_FAULT;
    endcase
  end

  // Output decode; ir_write and the MEMORY completion strobes are Mealy on ready.
  always_comb begin
    imem_req    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    next_pc_src = 1'b0;
    ru_write_en = 1'b0;
    dm_req      = 1'b0;
    dm_write_en = 1'b0;
    retire      = 1'b0;
    halted      = 1'b0;
    fault       = 1'b0;
    case (r_state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) ir_write = 1'b1;
        else            ir_write = 1'b0;
      end
      ST_EXECUTE: begin
        if (r_op_class == OC_BRANCH) begin
          pc_write    = 1'b1;
          next_pc_src = branch_taken;
          retire      = 1'b1;
        end else begin
          pc_write    = 1'b0;
        end
      end
      ST_MEMORY: begin
        dm_req      = 1'b1;
        dm_write_en = (r_op_class == OC_STORE);
        if (dmem_ready && (r_op_class == OC_STORE)) begin
          pc_write = 1'b1;
          retire   = 1'b1;
        end else begin
          pc_write = 1'b0;
        end
      end
      ST_WRITEBACK: begin
        ru_write_en = 1'b1;
        pc_write    = 1'b1;
        next_pc_src = (r_op_class == OC_JUMP);
        retire      = 1'b1;
      end
      ST_HALT:  halted = 1'b1;
      ST_FAULT: fault  = 1'b1;
      default:  imem_req = 1'b0;
    endcase
  end

  assign instr_count = r_instr_count;
  assign state       = state_bits(r_state);

endmodule
